// File: rtl/wb_queue_if.sv
// Write-back port bundle: ALU result, long-latency handshake, register file
// write port and the decode busy query.
interface wb_queue_if #(
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32
);
    logic              aluWr;
    logic [4:0]        aluAddr;
    logic [DATA_W-1:0] aluData;
    logic              lsValid;
    logic [4:0]        lsAddr;
    logic [DATA_W-1:0] lsData;
    logic              lsReady;
    logic              regWr;
    logic [4:0]        WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        qAddr;
    logic              qBusy;
    logic [PTR_W:0]    count;

    modport slave (
        input  aluWr, aluAddr, aluData, lsValid, lsAddr, lsData, qAddr,
        output lsReady, regWr, WriteAddr, WriteData, qBusy, count
    );

    modport master (
        output aluWr, aluAddr, aluData, lsValid, lsAddr, lsData, qAddr,
        input  lsReady, regWr, WriteAddr, WriteData, qBusy, count
    );
endinterface

// File: rtl/wb_queue.sv
// Register file write-back arbiter: ALU results take the write port first,
// long-latency results wait in a small in-order FIFO.
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32
) (
    input logic       CLK,
    input logic       reset,
    wb_queue_if.slave bus
);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [4:0]        entryAddr [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];
    logic [DEPTH-1:0]  entryValid;

    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W:0]    count;

    logic              regWr;
    logic [4:0]        writeAddr;
    logic [DATA_W-1:0] writeData;

    logic              lsReady;
    logic              aluSel;
    logic              pushEn;
    logic              popEn;
    logic              hit;

    assign lsReady = !reset && (count != FULL_COUNT);
    assign aluSel  = bus.aluWr && (bus.aluAddr != 5'd0);
    // Writes to $0 are acknowledged but never occupy a slot.
    assign pushEn  = bus.lsValid && lsReady && (bus.lsAddr != 5'd0);
    assign popEn   = !aluSel && (count != '0);

    always_ff @(posedge CLK) begin
        if (pushEn) begin
            entryAddr[wrPtr] <= bus.lsAddr;
            entryData[wrPtr] <= bus.lsData;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
            regWr      <= 1'b0;
            writeAddr  <= '0;
            writeData  <= '0;
        end else begin
            if (popEn) begin
                entryValid[rdPtr] <= 1'b0;
                rdPtr             <= rdPtr + 1'b1;
            end
            if (pushEn) begin
                entryValid[wrPtr] <= 1'b1;
                wrPtr             <= wrPtr + 1'b1;
            end
            count <= count + {{PTR_W{1'b0}}, pushEn} - {{PTR_W{1'b0}}, popEn};

            if (aluSel) begin
                regWr     <= 1'b1;
                writeAddr <= bus.aluAddr;
                writeData <= bus.aluData;
            end else if (popEn) begin
                regWr     <= 1'b1;
                writeAddr <= entryAddr[rdPtr];
                writeData <= entryData[rdPtr];
            end else begin
                regWr <= 1'b0;
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && (entryAddr[i] == bus.qAddr)) hit = 1'b1;
        end
    end

    assign bus.qBusy     = (bus.qAddr != 5'd0) &&
                           (hit || (regWr && (writeAddr == bus.qAddr)));
    assign bus.lsReady   = lsReady;
    assign bus.regWr     = regWr;
    assign bus.WriteAddr = writeAddr;
    assign bus.WriteData = writeData;
    assign bus.count     = count;
endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: a queue-based reference model predicts every
// cycle's port state; a negedge monitor pops and compares.
module tb_wb_queue;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;
    localparam int DATA_W = 32;

    logic CLK = 1'b0;
    logic reset;

    wb_queue_if #(.PTR_W(PTR_W), .DATA_W(DATA_W)) bus();

    wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W)) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entT;

    typedef struct {
        logic        regWr;
        logic [4:0]  addr;
        logic [31:0] data;
        int          count;
        logic        ready;
        logic        busy;
    } expT;

    entT         modelFifo[$];
    expT         expQ[$];
    logic        mRegWr;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    int          nAssert = 0;
    int          nFail   = 0;

    // Reference behaviour at a rising edge, using the inputs held before it.
    task automatic modelEdge();
        bit  room;
        entT e;
        if (reset) begin
            modelFifo.delete();
            mRegWr = 1'b0;
            mAddr  = '0;
            mData  = '0;
        end else begin
            room = modelFifo.size() < DEPTH;
            if (bus.aluWr && bus.aluAddr != 0) begin
                mRegWr = 1'b1;
                mAddr  = bus.aluAddr;
                mData  = bus.aluData;
            end else if (modelFifo.size() > 0) begin
                e      = modelFifo.pop_front();
                mRegWr = 1'b1;
                mAddr  = e.addr;
                mData  = e.data;
            end else begin
                mRegWr = 1'b0;
            end
            if (bus.lsValid && room && bus.lsAddr != 0)
                modelFifo.push_back('{addr: bus.lsAddr, data: bus.lsData});
        end
    endtask

    task automatic drive(input logic r, input logic aw, input logic [4:0] aa,
                         input logic [31:0] ad, input logic lv, input logic [4:0] la,
                         input logic [31:0] ld, input logic [4:0] qa);
        expT x;
        @(posedge CLK);
        modelEdge();
        #1;
        reset       = r;
        bus.aluWr   = aw;
        bus.aluAddr = aa;
        bus.aluData = ad;
        bus.lsValid = lv;
        bus.lsAddr  = la;
        bus.lsData  = ld;
        bus.qAddr   = qa;
        x.regWr = mRegWr;
        x.addr  = mAddr;
        x.data  = mData;
        x.count = modelFifo.size();
        x.ready = !r && (modelFifo.size() < DEPTH);
        x.busy  = 1'b0;
        if (qa != 0) begin
            if (mRegWr && mAddr == qa) x.busy = 1'b1;
            foreach (modelFifo[i]) if (modelFifo[i].addr == qa) x.busy = 1'b1;
        end
        expQ.push_back(x);
    endtask

    task automatic idle(input int n, input logic [4:0] qa);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, qa);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        expT x;
        forever begin
            @(negedge CLK);
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                check("regWr",     {31'd0, bus.regWr},   {31'd0, x.regWr});
                check("WriteAddr", {27'd0, bus.WriteAddr}, {27'd0, x.addr});
                check("WriteData", bus.WriteData,        x.data);
                check("count",     {29'd0, bus.count},   x.count);
                check("lsReady",   {31'd0, bus.lsReady}, {31'd0, x.ready});
                check("qBusy",     {31'd0, bus.qBusy},   {31'd0, x.busy});
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int          aluPct;
        logic [4:0]  aa, la;
        reset       = 1'b1;
        bus.aluWr   = 1'b0;
        bus.aluAddr = '0;
        bus.aluData = '0;
        bus.lsValid = 1'b0;
        bus.lsAddr  = '0;
        bus.lsData  = '0;
        bus.qAddr   = '0;
        repeat (3) drive(1, 0, 0, 0, 1, 3, 32'h5, 3);

        // ALU only
        drive(0, 1, 5, 32'h1234, 0, 0, 0, 5);
        idle(3, 5);
        // long-latency into an idle queue
        drive(0, 0, 0, 0, 1, 7, 32'hAAAA, 7);
        idle(4, 7);
        // ALU priority starves the FIFO
        drive(0, 1, 8, 32'h8, 1, 3, 32'h11, 3);
        drive(0, 1, 9, 32'h9, 1, 4, 32'h22, 4);
        drive(0, 1, 10, 32'hA, 0, 0, 0, 3);
        idle(4, 4);
        // fill to DEPTH under ALU pressure, then drain and wrap
        for (int i = 0; i < 6; i++)
            drive(0, 1, 5'(11 + i), 32'(i), 1, 5'(1 + i), 32'h100 + 32'(i), 5'(1 + i));
        idle(6, 2);
        drive(0, 0, 0, 0, 1, 12, 32'hC0DE, 12);
        drive(0, 0, 0, 0, 1, 13, 32'hBEEF, 13);
        idle(4, 13);
        // $0 handling
        drive(0, 0, 0, 0, 1, 0, 32'hDEAD, 0);
        drive(0, 1, 20, 32'h20, 1, 6, 32'h66, 6);
        drive(0, 1, 0, 32'hFFFF, 0, 0, 0, 0);
        idle(3, 0);
        // reset with queued entries
        for (int i = 0; i < 3; i++)
            drive(0, 1, 5'(21 + i), 32'(i), 1, 5'(25 + i), 32'h200 + 32'(i), 25);
        drive(1, 0, 0, 0, 0, 0, 0, 25);
        idle(4, 26);

        for (int i = 0; i < 3000; i++) begin
            case ((i / 400) % 4)
                0:       aluPct = 90;
                1:       aluPct = 15;
                2:       aluPct = 50;
                default: aluPct = 98;
            endcase
            aa = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
            la = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
            if ($urandom_range(0, 30) == 0) la = 5'($urandom_range(10, 31));
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 99) < aluPct, aa, $urandom,
                  $urandom_range(0, 99) < 70, la, $urandom,
                  5'($urandom_range(0, 10)));
        end

        idle(8, 0);
        repeat (3) @(negedge CLK);
        nAssert++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL drain: %0d expected entries left, required 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back side of the register file: the producer that drives the register file write port (regWr / WriteAddr / WriteData).
- Merges two result sources into the single write port:
  - the single-cycle ALU path, which is always accepted and has priority;
  - the long-latency load/multiply path, which uses a valid/ready handshake and is buffered in a small FIFO.
- Also gives decode a busy query, so it can stall on registers with writes still pending.

Parameters:
DEPTH, 4, number of FIFO entries for long-latency results (power of 2, ≥2)
PTR_W, 2, log2(DEPTH)
DATA_W, 32, result data width

Ports:
CLK  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
aluWr  input  1  ALU result valid this cycle
aluAddr  input  5  ALU destination register
aluData  input  DATA_W  ALU result
lsValid  input  1  long-latency result offered
lsAddr  input  5  long-latency destination register
lsData  input  DATA_W  long-latency result
lsReady  output  1  FIFO can accept; transfer when lsValid && lsReady
regWr  output  1  register file write enable (registered)
WriteAddr  output  5  register file write address (registered)
WriteData  output  DATA_W  register file write data (registered)
qAddr  input  5  decode query register
qBusy  output  1  a write to qAddr is queued or is in the output register
count  output  PTR_W+1  current FIFO occupancy

Behaviour:
- Reset (reset=1 at a rising edge):
  - rdPtr=wrPtr=0, count=0, regWr=0, WriteAddr=0, WriteData=0.
  - All FIFO entries are invalid; queued results are discarded mid-operation, with no write issued.
  - lsReady=0 while reset is high.
- lsReady is combinational: lsReady = !reset && (count != DEPTH). There is no pass-through when full, even if a pop occurs the same cycle.
- Push: lsValid && lsReady at an edge stores {lsAddr, lsData} at wrPtr and increments wrPtr (wraps modulo DEPTH).
  - If lsAddr==0, the transfer is accepted but nothing is stored (register $0 is never written).
- Output register selection, evaluated each cycle and loaded at the edge:
  1. aluWr && aluAddr!=0 → regWr=1, WriteAddr=aluAddr, WriteData=aluData.
  2. else if count!=0 → pop the head (rdPtr): regWr=1 with the head entry; rdPtr increments and wraps.
  3. else → regWr=0, WriteAddr/WriteData hold their previous values.
- An ALU write to $0 counts as no ALU write, so the FIFO may drain that cycle.
- Latency:
  - ALU result at edge N is visible on the write port during cycle N+1.
  - A long-latency result pushed into an empty FIFO at edge N pops at edge N+1 at the earliest and is visible during N+2. An entry is never pushed and popped on the same edge.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- count = pushes − pops; it never exceeds DEPTH and never goes below 0.
- Sustained ALU writes starve the FIFO. This is allowed; the FIFO fills and lsReady deasserts until an ALU-free cycle.
- FIFO entries drain strictly in arrival order.
- WAW ordering between the two sources is not enforced here. Decode must stall using qBusy.
- qBusy is combinational: qAddr!=0 && (any valid FIFO entry has addr==qAddr || (regWr && WriteAddr==qAddr)).

Test Plan:
- Reset, then ALU only: aluWr=1, aluAddr=5, aluData=0x1234 at edge 1 → regWr=1, WriteAddr=5, WriteData=0x1234 in cycle 2; regWr=0 in cycle 3 with no further input. Outputs are 0 and lsReady=0 while reset is high.
- Long-latency into an idle queue: push (7, 0xAAAA) at edge 1 → count=1 after edge 1, qBusy=1 for qAddr=7; write port shows (7, 0xAAAA) in cycle 3; count=0 and qBusy=0 after the write retires.
- Priority and starvation: push (3, 0x11) and (4, 0x22) while aluWr=1 for 3 cycles (addrs 8, 9, 10) → port writes 8, 9, 10, then 3, then 4 on consecutive cycles.
- Full and wrap: aluWr held 1, push 4 entries → count=4, lsReady=0, a 5th lsValid is not accepted. Release aluWr → 4 pops in order, pointers wrap. Push 2 more → correct order and data.
- $0 handling: push lsAddr=0 → accepted, count stays 0. aluWr=1 with aluAddr=0 while the FIFO holds 1 entry → the FIFO entry pops that cycle. qAddr=0 → qBusy=0 always.
- Mid-operation reset: FIFO holds 3 entries, assert reset for 1 cycle → count=0, regWr=0, no queued write ever appears, lsReady=1 the cycle after reset drops.
